// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the two ROM requesters (IF, LD), the ROM and the arbiter.
// The arbiter takes the slave view; the requesters and the ROM take the master view.
interface rom_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              ld_req_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic              ld_gnt_o;
    logic              ld_rvalid_o;
    logic [DATA_W-1:0] ld_rdata_o;

    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic              ld_starved_o;

    modport slave (
        input  if_req_i, if_addr_i, ld_req_i, ld_addr_i, rom_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
               ld_gnt_o, ld_rvalid_o, ld_rdata_o,
               rom_addr_o, ld_starved_o
    );

    modport master (
        output if_req_i, if_addr_i, ld_req_i, ld_addr_i, rom_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
               ld_gnt_o, ld_rvalid_o, ld_rdata_o,
               rom_addr_o, ld_starved_o
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM between instruction fetch (IF) and data load (LD).
// IF has priority; LD is forced through after MAX_WAIT consecutive lost cycles.
// ROM data is registered and returned one cycle after the granting cycle.
module rom_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 3
) (
    input logic               clk,
    input logic               rst,
    rom_port_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        IF_RSP,
        LD_RSP
    } rsp_st_e;

    rsp_st_e           rsp_st_q, rsp_st_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              starved;
    logic              if_gnt;
    logic              ld_gnt;
    logic [ADDR_W-1:0] rom_addr;

    // Grants and ROM address: purely from requests and the registered wait counter.
    always_comb begin
        starved  = (wait_cnt_q == MAX_WAIT_C);
        ld_gnt   = bus.ld_req_i && (!bus.if_req_i || starved);
        if_gnt   = bus.if_req_i && !ld_gnt;
        rom_addr = '0;
        if (if_gnt) begin
            rom_addr = bus.if_addr_i;
        end else if (ld_gnt) begin
            rom_addr = bus.ld_addr_i;
        end
    end

    // Wait counter: counts consecutive LD losses, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = '0;
        if (bus.ld_req_i && !ld_gnt) begin
            wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
        end
    end

    // Response FSM next state and data capture on any granted cycle.
    always_comb begin
        rsp_st_d = IDLE;
        data_d   = data_q;
        if (if_gnt) begin
            rsp_st_d = IF_RSP;
        end else if (ld_gnt) begin
            rsp_st_d = LD_RSP;
        end
        if (if_gnt || ld_gnt) begin
            data_d = bus.rom_data_i;
        end
    end

    // State, counter and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_st_q   <= IDLE;
            wait_cnt_q <= '0;
            data_q     <= '0;
        end else begin
            rsp_st_q   <= rsp_st_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
        end
    end

    assign bus.if_gnt_o     = if_gnt;
    assign bus.ld_gnt_o     = ld_gnt;
    assign bus.rom_addr_o   = rom_addr;
    assign bus.ld_starved_o = starved && bus.ld_req_i;
    assign bus.if_rvalid_o  = (rsp_st_q == IF_RSP);
    assign bus.ld_rvalid_o  = (rsp_st_q == LD_RSP);
    assign bus.if_rdata_o   = data_q;
    assign bus.ld_rdata_o   = data_q;
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters:
  - the core instruction-fetch port (IF);
  - a data-load port (LD) used for constant/table reads.
- Arbitrates each cycle and drives the ROM address.
- Registers the ROM output and returns it, one cycle later, to the requester that won.
- Sits between rv_core and rom inside the SoC top.

Parameters:
- ADDR_W, 8, ROM word-address width ($clog2 of ROM depth).
- DATA_W, 32, ROM word width.
- MAX_WAIT, 3, consecutive lost cycles after which LD is forced to win (valid range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req_i  input  1  fetch request.
- if_addr_i  input  ADDR_W  fetch word address.
- if_gnt_o  output  1  fetch granted this cycle.
- if_rvalid_o  output  1  fetch data valid.
- if_rdata_o  output  DATA_W  fetch data.
- ld_req_i  input  1  load request.
- ld_addr_i  input  ADDR_W  load word address.
- ld_gnt_o  output  1  load granted this cycle.
- ld_rvalid_o  output  1  load data valid.
- ld_rdata_o  output  DATA_W  load data.
- rom_addr_o  output  ADDR_W  address to ROM.
- rom_data_i  input  DATA_W  combinational ROM data.
- ld_starved_o  output  1  high while the forced-LD condition is active.

Behaviour:
Decided interface:
- One clock; reset is asynchronous and active-high.
- Ports are clk and rst.

Handshake:
- A requester holds req and addr stable until it sees gnt high in the same cycle.
- Transfer occurs on a cycle with req && gnt.
- Grants are combinational from the req inputs and the registered wait counter. There is no comb path from rom_data_i to the grants.
- A requester may drop req before it is granted; no transfer happens.

Arbitration:
- Only IF requests: IF wins.
- Only LD requests: LD wins.
- Both request and wait_cnt < MAX_WAIT: IF wins.
- Both request and wait_cnt == MAX_WAIT: LD wins.
- ld_starved_o = (wait_cnt == MAX_WAIT) && ld_req_i.
- At most one gnt is high per cycle.

Wait counter (4 bit):
- Increments when ld_req_i && !ld_gnt_o.
- Clears to 0 on an LD grant or when ld_req_i is low.
- Saturates at MAX_WAIT.

ROM address:
- rom_addr_o = if_addr_i when IF is granted, ld_addr_i when LD is granted, 0 when neither is granted.

Response FSM (state register rsp_st):
- States: IDLE, IF_RSP, LD_RSP.
- Next state each edge: IF_RSP if IF is granted, LD_RSP if LD is granted, else IDLE.
- Transitions are allowed from any state to any state, so back-to-back grants run at full throughput: one transfer per cycle.
- A data register captures rom_data_i on every granted edge and holds its value otherwise.

Response outputs:
- if_rvalid_o = (rsp_st == IF_RSP); ld_rvalid_o = (rsp_st == LD_RSP).
- Latency: data is valid exactly 1 cycle after the granting cycle.
- Both rdata outputs present the data register. Only the matching rvalid qualifies it.
- rvalid lasts a single cycle. There is no back-pressure on responses.

Reset (asynchronous, any time, including mid-transfer):
- rsp_st = IDLE, wait_cnt = 0, data register = 0.
- All rvalid outputs are 0; rdata outputs are 0.
- Grants and rom_addr_o follow their combinational equations.
- A grant issued in the cycle rst rises produces no response.

Test Plan:
- Reset, then IF only: if_addr_i = 0x05 with ROM[5] = 0x00500093 held 3 cycles -> if_gnt_o = 1 each cycle; if_rvalid_o = 1 on cycles 2..4 with data 0x00500093; ld_* outputs stay 0.
- Simultaneous requests: IF and LD both request continuously, MAX_WAIT = 3 -> IF wins cycles 1-3; ld_starved_o and ld_gnt_o are high on cycle 4; ld_rvalid_o is high on cycle 5; wait_cnt is back to 0; IF wins again on cycle 5.
- Back-to-back alternation: IF addr 0x10 then LD addr 0x20 on consecutive cycles -> if_rvalid_o then ld_rvalid_o on consecutive cycles with ROM[0x10] and ROM[0x20]; no bubble.
- LD request withdrawn before grant: LD requests 2 losing cycles, then drops ld_req_i -> wait_cnt clears to 0; no ld_rvalid_o.
- Reset mid-transfer: assert rst asynchronously between a grant edge and the next edge -> if_rvalid_o goes 0 immediately and no response follows; after release, the first IF grant returns valid data with 1-cycle latency.
- Idle: no requests for 5 cycles -> rom_addr_o = 0, all gnt/rvalid = 0, data register holds its last value.
